// File: rtl/shifter_pkg.sv
// Shared encodings for the universal shifter: operation modes and FSM states.
// Both enums are 2 bits wide so they map directly onto the mode port and state register.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next register value and the bit that falls out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it is evaluated every cycle and used only while shifting.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             cout_nxt
);

  always_comb begin
    q_nxt    = q;
    cout_nxt = 1'b0;
    case (mode)
      SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        cout_nxt = q[WIDTH-1];
      end
      SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        cout_nxt = q[0];
      end
      ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        cout_nxt = q[WIDTH-1];
      end
      ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        cout_nxt = q[0];
      end
      default: begin
        q_nxt    = q;
        cout_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shifter.sv
// Multi-step shift/rotate engine: load on start, then one step per cycle for 'amount' cycles.
// Latency: done pulses in the cycle beginning amount+1 edges after the start edge.
// Backpressure: start is ignored while busy; no flow control on the outputs.
module universal_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  state_e           state;
  mode_e            mode_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_nxt;
  logic             cout_nxt;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q       (q),
    .mode    (mode_r),
    .sin     (sin),
    .q_nxt   (q_nxt),
    .cout_nxt(cout_nxt)
  );

  // done is registered off the DONE state, so it trails the DONE cycle by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_r <= SHL;
      cnt    <= '0;
      q      <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q      <= din;
            cout   <= 1'b0;
            mode_r <= mode_e'(mode);
            cnt    <= amount;
            busy   <= 1'b1;
            state  <= (amount != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          q    <= q_nxt;
          cout <= cout_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shifter.sv
// Directed bench for universal_shifter: hand-computed shift results, latency, busy width,
// done pulse width, start-while-busy rejection and mid-operation reset.
module tb_universal_shifter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  universal_shifter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .amount(amount),
    .din   (din),
    .sin   (sin),
    .q     (q),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for done. lat counts edges after the start
  // edge until done is seen; busy_cyc counts sampled cycles with busy high; cout1 is cout
  // after the first step. With poke set, start is held high and the other inputs are
  // scrambled while the operation runs.
  task automatic run_op(input logic [1:0] m, input int amt, input logic [7:0] d,
                        input logic s, input bit poke,
                        output int lat, output int busy_cyc, output logic cout1);
    logic [CNT_W-1:0] amt_v;
    amt_v = amt[CNT_W-1:0];
    @(negedge clk);
    start = 1'b1; mode = m; amount = amt_v; din = d; sin = s;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cyc = busy ? 1 : 0; cout1 = 1'b0;
    if (poke) begin
      din = ~d; mode = ~m; amount = '1; start = 1'b1;
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (busy) busy_cyc++;
      if (i == 1) cout1 = cout;
      if (poke) start = (i <= amt);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk); #1;
    check(tag, done, 1'b0);
  endtask

  initial begin
    int lat, bc, extra;
    logic c1;

    rst_n = 1'b0; start = 1'b0; mode = 2'b00; amount = '0; din = '0; sin = 1'b0;
    #2;
    check("rst_q", q, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #20;
    @(negedge clk); rst_n = 1'b1;

    // SHL by 1
    run_op(2'b00, 1, 8'h01, 1'b0, 1'b0, lat, bc, c1);
    check("shl1_lat", lat, 2);
    check("shl1_q", q, 8'h02);
    check("shl1_cout", cout, 1'b0);
    check("shl1_busy_cyc", bc, 2);
    done_drops("shl1_done_width");

    // SHL by 8 pushes the single 1 out
    run_op(2'b00, 8, 8'h01, 1'b0, 1'b0, lat, bc, c1);
    check("shl8_lat", lat, 9);
    check("shl8_q", q, 8'h00);
    check("shl8_cout", cout, 1'b1);

    // ROR by 3 with sin high (must not leak in)
    run_op(2'b11, 3, 8'h81, 1'b1, 1'b0, lat, bc, c1);
    check("ror3_lat", lat, 4);
    check("ror3_q", q, 8'h30);
    check("ror3_cout", cout, 1'b0);
    check("ror3_cout_step1", c1, 1'b1);

    // SHR by 4 filling ones, start/inputs disturbed mid-operation
    run_op(2'b01, 4, 8'h00, 1'b1, 1'b1, lat, bc, c1);
    check("shr4_lat", lat, 5);
    check("shr4_q", q, 8'hF0);
    check("shr4_cout", cout, 1'b0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("shr4_extra_done", extra, 0);
    check("shr4_idle_busy", busy, 1'b0);
    check("shr4_hold_q", q, 8'hF0);

    // amount 0: load only
    run_op(2'b10, 0, 8'hA5, 1'b0, 1'b0, lat, bc, c1);
    check("amt0_lat", lat, 1);
    check("amt0_q", q, 8'hA5);
    check("amt0_busy_cyc", bc, 1);
    check("amt0_cout", cout, 1'b0);
    done_drops("amt0_done_width");

    // ROL by 10 (> WIDTH): equals rotate-left by 2
    run_op(2'b10, 10, 8'h96, 1'b1, 1'b0, lat, bc, c1);
    check("rol10_lat", lat, 11);
    check("rol10_q", q, 8'h5A);
    check("rol10_cout", cout, 1'b0);
    check("rol10_busy_cyc", bc, 11);

    // Reset in the middle of a 6-step SHL
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = 4'd6; din = 8'h01; sin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("abort_pre_q", q, 8'h04);
    check("abort_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_q", q, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_cout", cout, 1'b0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);
    run_op(2'b00, 2, 8'h03, 1'b1, 1'b0, lat, bc, c1);
    check("post_rst_lat", lat, 3);
    check("post_rst_q", q, 8'h0F);
    check("post_rst_cout", cout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/universal_shifter.md
UNIVERSAL_SHIFTER -- requirements
Module: universal_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the shift-amount field.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, the clock; all state changes occur on its rising edge.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start: input, 1 bit, request to begin an operation; sampled only in IDLE.
REQ-007 Port mode: input, 2 bits, operation select: 00 SHL, 01 SHR, 10 ROL, 11 ROR.
REQ-008 Port amount: input, CNT_W bits, number of single-bit shift steps to perform.
REQ-009 Port din: input, WIDTH bits, parallel load data.
REQ-010 Port sin: input, 1 bit, serial fill bit for SHL/SHR, sampled on every shift step.
REQ-011 Port q: output, WIDTH bits, the current register contents.
REQ-012 Port cout: output, 1 bit, the bit shifted or rotated out by the most recent step.
REQ-013 Port busy: output, 1 bit, high whenever the state is not IDLE.
REQ-014 Port done: output, 1 bit, a one-cycle pulse marking operation complete.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, when start=1 at a clock edge, the block SHALL load q<=din, clear cout, and capture mode and amount internally.
REQ-017 On that start edge, the next state SHALL be SHIFT if amount!=0 and DONE if amount==0.
REQ-018 Each edge in SHIFT SHALL perform one step using the captured mode and decrement the captured count by 1.
REQ-019 The FSM SHALL move from SHIFT to DONE on the edge where the count goes from 1 to 0.
REQ-020 SHL step: q<={q[WIDTH-2:0],sin}, cout<=q[WIDTH-1].
REQ-021 SHR step: q<={sin,q[WIDTH-1:1]}, cout<=q[0].
REQ-022 ROL step: q<={q[WIDTH-2:0],q[WIDTH-1]}, cout<=q[WIDTH-1].
REQ-023 ROR step: q<={q[0],q[WIDTH-1:1]}, cout<=q[0].
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-025 Latency: done SHALL be high during the cycle that begins amount+1 rising edges after the start edge.
REQ-026 start SHALL be ignored in SHIFT and DONE.
REQ-027 Changes to mode, amount, din or sin SHALL NOT affect an operation in progress, except that sin is sampled on each step.
REQ-028 An amount greater than WIDTH SHALL be legal and SHALL perform exactly amount steps.
REQ-029 The state of sin SHALL NOT affect ROL or ROR results.
REQ-030 q and cout SHALL hold their values in IDLE and DONE.

Reset
REQ-031 When rst_n=0, the block SHALL immediately drive the state to IDLE and q, cout, busy, done and the internal count to 0, regardless of clk.
REQ-032 A reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted normally.

Structure
REQ-034 The mode encodings (SHL, SHR, ROL, ROR) and the FSM state encodings SHALL be defined in a shared package, shifter_pkg.
REQ-035 One combinational sub-module, shift_step, SHALL compute the next q and cout from q, mode and sin; the FSM, counter and registers SHALL stay in universal_shifter.

Verification
REQ-036 WIDTH=8: din=8'h01, SHL, amount=1, sin=0 -> q=8'h02, cout=0, done 2 cycles after the start edge.
REQ-037 din=8'h01, SHL, amount=8, sin=0 -> q=8'h00, cout=1, done 9 cycles after the start edge.
REQ-038 din=8'h81, ROR, amount=3 -> q=8'h30, cout=0; cout=1 after step 1.
REQ-039 din=8'h00, SHR, amount=4, sin=1 -> q=8'hF0, cout=0; start pulses in SHIFT ignored (no extra done).
REQ-040 amount=0, din=8'hA5 -> q=8'hA5, busy high 1 cycle, done 1 cycle after the start edge.
REQ-041 rst_n low mid-SHIFT (amount=6, after step 2) -> q=0, busy=0, no done; next start runs correctly.
